// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between the upstream fetch/regfile stage, the decode
// register and the downstream ALU.
interface alu_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;

    // The environment drives instructions in and consumes decoded results
    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en, illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode stage for OP, OP-IMM, LUI and AUIPC: combinational decode
// into a single valid/ready pipeline register feeding the ALU.
module alu_decode_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SUB  = 4'b1011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_u  = {bus.instr[31:12], 12'b0};
    assign shamt  = {27'b0, bus.instr[24:20]};

    logic [31:0] alu_a_next;
    logic [31:0] alu_b_next;
    logic [3:0]  alu_ctrl_next;
    logic [4:0]  rd_next;
    logic        wb_en_next;
    logic        illegal_next;
    logic [3:0]  base_ctrl;

    // funct3 -> op map shared by OP and OP-IMM; funct7[5] selects SUB/SRA
    always_comb begin
        base_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  base_ctrl = ALU_ADD;
            3'b001:  base_ctrl = ALU_SLL;
            3'b010:  base_ctrl = ALU_SLT;
            3'b011:  base_ctrl = ALU_SLTU;
            3'b100:  base_ctrl = ALU_XOR;
            3'b101:  base_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  base_ctrl = ALU_OR;
            default: base_ctrl = ALU_AND;
        endcase
    end

    always_comb begin
        alu_a_next    = 32'b0;
        alu_b_next    = 32'b0;
        alu_ctrl_next = ALU_ADD;
        illegal_next  = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    illegal_next  = 1'b0;
                    alu_a_next    = bus.rs1_data;
                    alu_b_next    = bus.rs2_data;
                    alu_ctrl_next = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : base_ctrl;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (funct7 == F7_ZERO || (funct3 == 3'b101 && funct7 == F7_ALT)) begin
                        illegal_next  = 1'b0;
                        alu_a_next    = bus.rs1_data;
                        alu_b_next    = shamt;
                        alu_ctrl_next = base_ctrl;
                    end
                end else begin
                    illegal_next  = 1'b0;
                    alu_a_next    = bus.rs1_data;
                    alu_b_next    = imm_i;
                    alu_ctrl_next = base_ctrl;
                end
            end
            OPC_LUI: begin
                illegal_next = 1'b0;
                alu_b_next   = imm_u;
            end
            OPC_AUIPC: begin
                illegal_next = 1'b0;
                alu_a_next   = bus.pc;
                alu_b_next   = imm_u;
            end
            default: illegal_next = 1'b1;
        endcase
    end

    assign rd_next    = bus.instr[11:7];
    assign wb_en_next = !illegal_next && (rd_next != 5'd0);

    logic        out_valid_reg;
    logic [31:0] alu_a_reg;
    logic [31:0] alu_b_reg;
    logic [3:0]  alu_ctrl_reg;
    logic [4:0]  rd_reg;
    logic        wb_en_reg;
    logic        illegal_reg;
    logic        load;

    // Reset and flush both block acceptance so nothing is lost behind them
    assign bus.in_ready = !rst && !flush && (!out_valid_reg || bus.out_ready);
    assign load         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            alu_a_reg     <= 32'b0;
            alu_b_reg     <= 32'b0;
            alu_ctrl_reg  <= ALU_ADD;
            rd_reg        <= 5'd0;
            wb_en_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_ctrl_reg  <= alu_ctrl_next;
            rd_reg        <= rd_next;
            wb_en_reg     <= wb_en_next;
            illegal_reg   <= illegal_next;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.alu_ctrl  = alu_ctrl_reg;
    assign bus.rd        = rd_reg;
    assign bus.wb_en     = wb_en_reg;
    assign bus.illegal   = illegal_reg;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage: decode table, backpressure,
// flush and mid-stall reset.
module tb_alu_decode_stage;
    logic clk;
    logic rst;
    logic flush;
    int   errors;
    int   checks;

    alu_decode_stage_if bus ();

    alu_decode_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] ctrl,
                             input logic [4:0] rd, input logic wb, input logic ill);
        check({tag, ".valid"}, {31'b0, bus.out_valid}, {31'b0, vld});
        check({tag, ".a"},     bus.alu_a, a);
        check({tag, ".b"},     bus.alu_b, b);
        check({tag, ".ctrl"},  {28'b0, bus.alu_ctrl}, {28'b0, ctrl});
        check({tag, ".rd"},    {27'b0, bus.rd}, {27'b0, rd});
        check({tag, ".wb_en"}, {31'b0, bus.wb_en}, {31'b0, wb});
        check({tag, ".illegal"}, {31'b0, bus.illegal}, {31'b0, ill});
        $display("txn %-10s valid=%0b a=%08h b=%08h ctrl=%04b rd=%0d wb=%0b ill=%0b",
                 tag, bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rd,
                 bus.wb_en, bus.illegal);
    endtask

    task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = vld;
        bus.instr    = ins;
        bus.pc       = pc;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                        input logic [4:0] rd, input logic wb, input logic ill);
        drive(1'b1, ins, pc, r1, r2);
        #1;
        check({tag, ".in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        step();
        check_out(tag, 1'b1, a, b, ctrl, rd, wb, ill);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hFFF10093, 32'h0, 32'd5, 32'd0);
        step();
        step();
        check_out("reset", 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
        check("reset.in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b0;

        // Decode table, back-to-back at full throughput
        send("addi",   32'hFFF10093, 32'h0,   32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
        send("srai",   32'h40325193, 32'h0,   32'h80000000, 32'd9, 32'h80000000, 32'h00000003, 4'b1010, 5'd3, 1'b1, 1'b0);
        send("sub",    32'h407302B3, 32'h0,   32'd10,       32'd3, 32'd10,       32'd3,        4'b1011, 5'd5, 1'b1, 1'b0);
        send("lui",    32'h123450B7, 32'h40,  32'd7,        32'd8, 32'd0,        32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0);
        send("auipc",  32'h00001097, 32'h100, 32'd7,        32'd8, 32'h100,      32'h1000,     4'b0000, 5'd1, 1'b1, 1'b0);
        send("ecall",  32'h00000073, 32'h100, 32'd7,        32'd8, 32'd0,        32'd0,        4'b0000, 5'd0, 1'b0, 1'b1);
        send("add_x0", 32'h00208033, 32'h0,   32'd1,        32'd2, 32'd1,        32'd2,        4'b0000, 5'd0, 1'b0, 1'b0);
        send("slli",   32'h01F09093, 32'h0,   32'h1234,     32'd0, 32'h1234,     32'd31,       4'b1000, 5'd1, 1'b1, 1'b0);
        send("slli_bad", 32'h41F09093, 32'h0, 32'h1234,     32'd0, 32'd0,        32'd0,        4'b0000, 5'd1, 1'b0, 1'b1);
        send("or_f7bad", 32'h0241E133, 32'h0, 32'd3,        32'd4, 32'd0,        32'd0,        4'b0000, 5'd2, 1'b0, 1'b1);
        send("sltiu",  32'h8001B113, 32'h0,   32'd6,        32'd0, 32'd6,        32'hFFFFF800, 4'b0010, 5'd2, 1'b1, 1'b0);

        // Backpressure: held outputs, no acceptance, then back-to-back reload
        send("bp_load", 32'hFFF10093, 32'h0,  32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h123450B7 + (i << 7), 32'h0, 32'd77 + i, 32'd0);
            #1;
            check("stall.in_ready", {31'b0, bus.in_ready}, 32'd0);
            step();
            check_out("stall", 1'b1, 32'd5, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
        end
        bus.out_ready = 1'b1;
        send("bp_reload", 32'h407302B3, 32'h0, 32'd20,      32'd4, 32'd20,       32'd4,        4'b1011, 5'd5, 1'b1, 1'b0);

        // Consume with nothing new behind it
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        check("drain.valid", {31'b0, bus.out_valid}, 32'd0);

        // Flush with a pending entry and a competing input
        send("fl_load", 32'hFFF10093, 32'h0,  32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h123450B7, 32'h0, 32'd0, 32'd0);
        #1;
        check("flush.in_ready", {31'b0, bus.in_ready}, 32'd0);
        step();
        check("flush.valid", {31'b0, bus.out_valid}, 32'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        check("flush.not_accepted", {31'b0, bus.out_valid}, 32'd0);
        check("flush.b_stale", bus.alu_b, 32'hFFFFFFFF);

        // Reset in the middle of a stall
        send("rs_load", 32'h407302B3, 32'h0,  32'd9,        32'd2, 32'd9,        32'd2,        4'b1011, 5'd5, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00001097, 32'h200, 32'd0, 32'd0);
        step();
        rst = 1'b1;
        step();
        check_out("mid_rst", 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
        check("mid_rst.in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that sits in front of the RV32I ALU and produces its operands and 4-bit operation code. It accepts a fetched instruction plus register-file read data and PC over a valid/ready handshake. It decodes OP, OP-IMM, LUI and AUIPC into `alu_a`/`alu_b`/`alu_ctrl` plus writeback info, and holds the result in a single pipeline register with backpressure and flush.

## Interface
- No parameters (XLEN fixed at 32).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous; discards the held entry.
- `in_valid` in 1: upstream presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `instr` in 32: RV32I instruction word.
- `pc` in 32: instruction address.
- `rs1_data` in 32: value of `x[instr[19:15]]`.
- `rs2_data` in 32: value of `x[instr[24:20]]`.
- `out_valid` out 1: registered outputs hold a decoded instruction.
- `out_ready` in 1: ALU/execute consumes this cycle.
- `alu_a` out 32: ALU operand a.
- `alu_b` out 32: ALU operand b.
- `alu_ctrl` out 4: ALU op code.
- `rd` out 5: destination register.
- `wb_en` out 1: result must be written to `rd`.
- `illegal` out 1: instruction not handled by this stage.

## Operation
- `alu_ctrl` encoding:
  - 0000 ADD
  - 0001 SLT
  - 0010 SLTU
  - 0011 XOR
  - 0100 OR
  - 0111 AND
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - 1011 SUB
  - Other codes are never emitted.
- OP (opcode 0110011): a=rs1_data, b=rs2_data.
  - funct3 000: ADD if funct7=0000000, SUB if 0100000.
  - funct3 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 110: OR. 111: AND (all require funct7=0000000).
  - funct3 101: SRL if funct7=0000000, SRA if 0100000.
  - Any other funct7 is illegal.
- OP-IMM (0010011): a=rs1_data, b=sign-extended instr[31:20]; same funct3 map, but 000 is always ADD.
  - SLLI requires funct7=0000000.
  - SRLI requires funct7=0000000; SRAI requires funct7=0100000.
  - For all three shifts, b={27'b0, instr[24:20]} (funct7 bits are not passed to the ALU).
  - Other funct7 on a shift is illegal.
- LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD.
- AUIPC (0010111): a=pc, b={instr[31:12],12'b0}, ADD.
- Any other opcode, or an illegal funct7 as above:
  - illegal=1, wb_en=0, alu_ctrl=0000, a=0, b=0.
  - rd is still instr[11:7].
- rd=instr[11:7]. wb_en=1 only for a legal instruction with rd≠0.
- Decode is combinational from the inputs; the results are captured into the output register.

## Timing
- Reset values: out_valid=0, alu_a=0, alu_b=0, alu_ctrl=0000, rd=0, wb_en=0, illegal=0.
- in_ready = !out_valid || out_ready (combinational). in_ready is 0 during the reset cycle.
- Transfer in: in_valid && in_ready at edge N.
  - Decoded fields are visible from N+1 with out_valid=1.
  - Latency is 1 cycle.
- Transfer out: out_valid && out_ready.
  - If no new input is accepted in the same cycle, out_valid goes to 0 next cycle.
- Simultaneous consume and accept: the register reloads with the new instruction; out_valid stays 1. Full throughput is 1 instruction/cycle.
- Stall: out_valid=1 and out_ready=0.
  - All outputs are held stable.
  - in_ready=0; input changes are ignored.
- Priority: rst > flush > load.
  - flush=1: out_valid=0 next cycle; the data fields may keep stale values.
  - flush forces in_ready=0 in that cycle, so an input presented with flush is not accepted.
- Data fields change only on a load; out_valid alone qualifies them.

## Test plan
- ADDI x1,x2,-1 (`0xFFF10093`), rs1_data=5, out_ready=1 -> next cycle out_valid=1, a=5, b=0xFFFFFFFF, ctrl=0000, rd=1, wb_en=1, illegal=0.
- SRAI x3,x4,3 (`0x40325193`), rs1_data=0x80000000 -> b=0x00000003, ctrl=1010, rd=3. SUB x5,x6,x7 (`0x407302B3`) -> ctrl=1011, b=rs2_data.
- LUI x1,0x12345 (`0x123450B7`) -> a=0, b=0x12345000, ctrl=0000. AUIPC with pc=0x100, imm=1 (`0x00001097`) -> a=0x100, b=0x1000.
- ECALL (`0x00000073`) -> illegal=1, wb_en=0, ctrl=0000. ADD x0,x1,x2 (`0x00208033`) -> illegal=0, wb_en=0.
- Backpressure: load ADDI, then hold out_ready=0 for 3 cycles while changing instr -> outputs stable, in_ready=0; raise out_ready with a new in_valid -> back-to-back reload, out_valid stays 1.
- flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not accepted. rst asserted mid-stall -> all outputs at reset values next cycle.
